composer_mlayer: RTL and testbench

- Parametrised successor to the fixed two-layer composer.
- Generates horizontal/vertical scan counters, fractional scaled line-buffer indices, line IRQ, interlace field tracking and render/erase strobes.
- Composes NUM_LAYERS tile/bitmap layers plus one sprite plane with programmable sprite depth and a per-layer transparent colour key.
- Sits between the layer/sprite renderers (line buffers) and the display timing/output unit; output is fully registered.

---
 rtl/composer_pkg.sv | 26 ++
 rtl/composer_mlayer_if.sv | 26 ++
 rtl/composer_mlayer_mix.sv | 41 ++++
 rtl/composer_mlayer.sv | 148 ++++++++++++++
 tb/tb_composer_mlayer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/composer_pkg.sv
// Shared constants and helpers for the multi-layer composer.
// Sprite depth encoding, default scaling limits and the packed per-layer slice helper.
package composer_pkg;

    localparam int Z_NONE        = 0;
    localparam int Z_BOTTOM      = 1;
    localparam int MAX_X_DEFAULT = 640;
    localparam int MAX_Y_DEFAULT = 480;

    // Widest supported packed layer vector: 4 layers of up to 16-bit colour.
    localparam int SLICE_MAX_W = 16;
    localparam int SLICE_VEC_W = 4 * SLICE_MAX_W;

    function automatic logic [SLICE_MAX_W-1:0] layer_slice(
        input logic [SLICE_VEC_W-1:0] vec,
        input int                     idx,
        input int                     w
    );
        logic [SLICE_VEC_W-1:0] shifted;
        logic [SLICE_MAX_W-1:0] mask;
        shifted = vec >> (idx * w);
        mask    = (SLICE_MAX_W'(1) << w) - SLICE_MAX_W'(1);
        return shifted[SLICE_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/composer_mlayer_if.sv
// Line-buffer side of the composer: read indices and render strobes out,
// layer and sprite line-buffer data back in.
interface composer_mlayer_if #(
    parameter int NUM_LAYERS = 2,
    parameter int COLOR_W    = 8,
    parameter int Z_W        = 2,
    parameter int H_W        = 10,
    parameter int V_W        = 9
);
    logic [NUM_LAYERS*COLOR_W-1:0] layer_lb_rddata;
    logic [COLOR_W+Z_W-1:0]        sprite_lb_rddata;
    logic [H_W-1:0]                lb_rdidx;
    logic [V_W-1:0]                line_idx;
    logic                          line_render_start;
    logic                          sprite_lb_erase_start;

    modport master (
        output lb_rdidx, line_idx, line_render_start, sprite_lb_erase_start,
        input  layer_lb_rddata, sprite_lb_rddata
    );

    modport slave (
        input  lb_rdidx, line_idx, line_render_start, sprite_lb_erase_start,
        output layer_lb_rddata, sprite_lb_rddata
    );
endinterface

// File: rtl/composer_mlayer_mix.sv
// Combinational priority mux: paints bottom to top, interleaving the sprite
// plane at its programmed depth between the keyed background layers.
module composer_mix
    import composer_pkg::*;
#(
    parameter int NUM_LAYERS = 2,
    parameter int COLOR_W    = 8,
    parameter int Z_W        = 2
) (
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_data,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_key,
    input  logic [NUM_LAYERS-1:0]         layer_enable,
    input  logic [COLOR_W+Z_W-1:0]        sprite_data,
    input  logic                          sprites_enabled,
    output logic [COLOR_W-1:0]            pixel
);

    logic [COLOR_W-1:0] spr_col;
    logic [Z_W-1:0]     spr_z;
    logic               spr_on;

    assign spr_col = sprite_data[COLOR_W-1:0];
    assign spr_z   = sprite_data[COLOR_W+Z_W-1:COLOR_W];
    assign spr_on  = sprites_enabled && (spr_col != '0) && (32'(spr_z) != Z_NONE);

    always_comb begin
        logic [COLOR_W-1:0] data_i;
        logic [COLOR_W-1:0] key_i;
        pixel = '0;
        if (spr_on && 32'(spr_z) == Z_BOTTOM) pixel = spr_col;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            data_i = COLOR_W'(layer_slice(SLICE_VEC_W'(layer_data), i, COLOR_W));
            key_i  = COLOR_W'(layer_slice(SLICE_VEC_W'(layer_key), i, COLOR_W));
            if (layer_enable[i] && data_i != key_i) pixel = data_i;
            // Depth is compared at 32 bits so i+2 never aliases onto z=0.
            if (spr_on && 32'(spr_z) == i + 2) pixel = spr_col;
        end
        if (spr_on && 32'(spr_z) > NUM_LAYERS) pixel = spr_col;
    end

endmodule

// File: rtl/composer_mlayer.sv
// Scan counters, fractional line-buffer scaling, line IRQ, field tracking and
// a two-stage registered composition of NUM_LAYERS layers plus sprites.
module composer_mlayer
    import composer_pkg::*;
#(
    parameter int NUM_LAYERS = 2,
    parameter int COLOR_W    = 8,
    parameter int Z_W        = 2,
    parameter int H_W        = 10,
    parameter int V_W        = 9,
    parameter int FRAC_W     = 8,
    parameter int MAX_X      = MAX_X_DEFAULT,
    parameter int MAX_Y      = MAX_Y_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          interlaced,
    input  logic [FRAC_W-1:0]             frac_x_incr,
    input  logic [FRAC_W-1:0]             frac_y_incr,
    input  logic [COLOR_W-1:0]            border_color,
    input  logic [H_W-1:0]                active_hstart,
    input  logic [H_W-1:0]                active_hstop,
    input  logic [V_W-1:0]                active_vstart,
    input  logic [V_W-1:0]                active_vstop,
    input  logic [V_W-1:0]                irqline,
    input  logic [NUM_LAYERS-1:0]         layer_enable,
    input  logic                          sprites_enabled,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_key,
    input  logic                          display_next_frame,
    input  logic                          display_next_line,
    input  logic                          display_next_pixel,
    input  logic                          display_current_field,
    output logic                          current_field,
    output logic                          line_irq,
    output logic [V_W-1:0]                scanline,
    output logic [COLOR_W-1:0]            display_data,
    output logic                          display_valid,
    composer_mlayer_if.master             lb
);

    localparam int SX_W = H_W + FRAC_W - 1;
    localparam int SY_W = V_W + FRAC_W - 1;
    localparam logic [SX_W-1:0] MAX_X_FX = SX_W'(MAX_X << (FRAC_W - 1));
    localparam logic [SY_W-1:0] MAX_Y_FX = SY_W'(MAX_Y << (FRAC_W - 1));

    logic [V_W:0]         y_q, y_d, y_line_q, y_line_d;
    logic [H_W:0]         x_cnt_q, x_cnt_d;
    logic [SX_W-1:0]      sx_q, sx_d;
    logic [SY_W-1:0]      sy_q, sy_d;
    logic                 field_q, field_d, irq_q, irq_d;
    logic                 line_eval_q, line_eval_d, started_q, started_d;
    logic                 render_q, render_d, active_q, active_d;
    logic                 valid_q, valid_d;
    logic [COLOR_W-1:0]   data_q, data_d, mix_pixel;
    logic [H_W-1:0]       x;
    logic                 hactive, vactive;
    logic [FRAC_W-1:0]    incr_x;
    logic [FRAC_W:0]      incr_y;
    logic [SX_W:0]        sx_sum;

    assign x       = x_cnt_q[H_W:1];
    assign hactive = (x >= active_hstart) && (x < active_hstop);
    assign vactive = (y_line_q >= {1'b0, active_vstart}) && (y_line_q < {1'b0, active_vstop})
                     && (sy_q < MAX_Y_FX);
    assign incr_x  = interlaced ? (frac_x_incr >> 1) : frac_x_incr;
    assign incr_y  = interlaced ? {frac_y_incr, 1'b0} : {1'b0, frac_y_incr};
    assign sx_sum  = {1'b0, sx_q} + (SX_W+1)'(incr_x);

    always_comb begin
        y_d         = y_q;
        y_line_d    = y_line_q;
        field_d     = field_q;
        x_cnt_d     = x_cnt_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        started_d   = started_q;
        render_d    = 1'b0;
        line_eval_d = display_next_line;
        if (display_next_frame) begin
            y_d     = (interlaced && !display_current_field) ? (V_W+1)'(1) : '0;
            field_d = !display_current_field;
        end else if (display_next_line) begin
            y_d = y_q + (interlaced ? (V_W+1)'(2) : (V_W+1)'(1));
        end
        if (display_next_line) y_line_d = y_q;

        if (interlaced) irq_d = display_next_line && (y_q[V_W:1] == {1'b0, irqline[V_W-1:1]});
        else            irq_d = display_next_line && (y_q == {1'b0, irqline});

        if (display_next_line) begin
            x_cnt_d = '0;
            sx_d    = '0;
        end else if (display_next_pixel) begin
            x_cnt_d = x_cnt_q + (interlaced ? (H_W+1)'(1) : (H_W+1)'(2));
            if (hactive && sx_q < MAX_X_FX)
                sx_d = (sx_sum > {1'b0, MAX_X_FX}) ? MAX_X_FX : sx_sum[SX_W-1:0];
        end

        // Vertical scaling runs the cycle after next_line, once y has advanced.
        if (line_eval_q) begin
            if (y_q >= {1'b0, active_vstart} && !started_q) begin
                started_d = 1'b1;
                render_d  = 1'b1;
                sy_d      = (interlaced && (field_q ^ active_vstart[0])) ? SY_W'(frac_y_incr) : '0;
            end else if (vactive) begin
                render_d = 1'b1;
                sy_d     = sy_q + SY_W'(incr_y);
            end
        end
        if (display_next_frame) started_d = 1'b0;

        active_d = hactive && vactive;
        valid_d  = active_q;
        data_d   = active_q ? mix_pixel : border_color;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= '0;  y_line_q <= '0;  x_cnt_q <= '0;  sx_q <= '0;  sy_q <= '0;
            field_q <= 1'b0;  irq_q <= 1'b0;  line_eval_q <= 1'b0;  started_q <= 1'b0;
            render_q <= 1'b0;  active_q <= 1'b0;  valid_q <= 1'b0;  data_q <= '0;
        end else begin
            y_q <= y_d;  y_line_q <= y_line_d;  x_cnt_q <= x_cnt_d;  sx_q <= sx_d;  sy_q <= sy_d;
            field_q <= field_d;  irq_q <= irq_d;  line_eval_q <= line_eval_d;  started_q <= started_d;
            render_q <= render_d;  active_q <= active_d;  valid_q <= valid_d;  data_q <= data_d;
        end
    end

    composer_mix #(.NUM_LAYERS(NUM_LAYERS), .COLOR_W(COLOR_W), .Z_W(Z_W)) u_mix (
        .layer_data      (lb.layer_lb_rddata),
        .layer_key       (layer_key),
        .layer_enable    (layer_enable),
        .sprite_data     (lb.sprite_lb_rddata),
        .sprites_enabled (sprites_enabled),
        .pixel           (mix_pixel)
    );

    assign current_field            = field_q;
    assign line_irq                 = irq_q;
    assign scanline                 = y_line_q[V_W] ? '1 : y_q[V_W-1:0];
    assign display_data             = data_q;
    assign display_valid            = valid_q;
    assign lb.lb_rdidx              = sx_q[SX_W-1 -: H_W];
    assign lb.line_idx              = sy_q[SY_W-1 -: V_W];
    assign lb.line_render_start     = render_q;
    assign lb.sprite_lb_erase_start = (x_cnt_q == {H_W'(MAX_X - 1), interlaced});

endmodule

// File: tb/tb_composer_mlayer.sv
// Directed bench for composer_mlayer (three layers): scan counters, scaling,
// line IRQ, field tracking, composition priority and mid-line reset.
module tb_composer_mlayer;

    localparam int NL = 3;
    localparam int CW = 8;
    localparam int ZW = 2;
    localparam int HW = 10;
    localparam int VW = 9;
    localparam int FW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, interlaced, sprites_enabled;
    logic [FW-1:0]   frac_x_incr, frac_y_incr;
    logic [CW-1:0]   border_color;
    logic [HW-1:0]   active_hstart, active_hstop;
    logic [VW-1:0]   active_vstart, active_vstop, irqline;
    logic [NL-1:0]   layer_enable;
    logic [NL*CW-1:0] layer_key;
    logic            display_next_frame, display_next_line, display_next_pixel;
    logic            display_current_field;
    logic            current_field, line_irq, display_valid;
    logic [VW-1:0]   scanline;
    logic [CW-1:0]   display_data;

    composer_mlayer_if #(.NUM_LAYERS(NL), .COLOR_W(CW), .Z_W(ZW), .H_W(HW), .V_W(VW)) lb_if ();

    composer_mlayer #(.NUM_LAYERS(NL), .COLOR_W(CW), .Z_W(ZW), .H_W(HW), .V_W(VW), .FRAC_W(FW)) dut (
        .clk(clk), .rst(rst), .interlaced(interlaced),
        .frac_x_incr(frac_x_incr), .frac_y_incr(frac_y_incr), .border_color(border_color),
        .active_hstart(active_hstart), .active_hstop(active_hstop),
        .active_vstart(active_vstart), .active_vstop(active_vstop), .irqline(irqline),
        .layer_enable(layer_enable), .sprites_enabled(sprites_enabled), .layer_key(layer_key),
        .display_next_frame(display_next_frame), .display_next_line(display_next_line),
        .display_next_pixel(display_next_pixel), .display_current_field(display_current_field),
        .current_field(current_field), .line_irq(line_irq), .scanline(scanline),
        .display_data(display_data), .display_valid(display_valid), .lb(lb_if)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_frame();
        display_next_frame = 1'b1;
        @(negedge clk);
        display_next_frame = 1'b0;
    endtask

    // Returns line_irq as seen right after the strobe; ends once scaling has updated.
    task automatic do_line(output logic irq);
        display_next_line = 1'b1;
        @(negedge clk);
        display_next_line = 1'b0;
        irq = line_irq;
        @(negedge clk);
    endtask

    task automatic do_pixel();
        display_next_pixel = 1'b1;
        @(negedge clk);
        display_next_pixel = 1'b0;
    endtask

    task automatic comp_vec(input string tag, input logic [1:0] z, input logic [7:0] col,
                            input logic [2:0] en, input logic se, input logic [7:0] exp);
        lb_if.sprite_lb_rddata = {z, col};
        layer_enable           = en;
        sprites_enabled        = se;
        tick(2);
        check(tag, display_data, exp);
    endtask

    logic irq;

    initial begin
        rst = 1'b1;  interlaced = 1'b0;  frac_x_incr = 8'd128;  frac_y_incr = 8'd128;
        border_color = 8'hEE;  active_hstart = '0;  active_hstop = 10'd1000;
        active_vstart = '0;  active_vstop = 9'd400;  irqline = 9'd511;
        layer_enable = 3'b111;  sprites_enabled = 1'b1;
        layer_key = {8'd9, 8'd0, 8'd0};
        lb_if.layer_lb_rddata = {8'd9, 8'd7, 8'd5};
        lb_if.sprite_lb_rddata = '0;
        display_next_frame = 1'b0;  display_next_line = 1'b0;  display_next_pixel = 1'b0;
        display_current_field = 1'b0;
        tick(3);

        check("rst_data",   display_data, 0);
        check("rst_valid",  display_valid, 0);
        check("rst_rdidx",  lb_if.lb_rdidx, 0);
        check("rst_lineidx", lb_if.line_idx, 0);
        check("rst_render", lb_if.line_render_start, 0);
        check("rst_erase",  lb_if.sprite_lb_erase_start, 0);
        check("rst_scan",   scanline, 0);
        check("rst_field",  current_field, 0);
        check("rst_irq",    line_irq, 0);
        rst = 1'b0;

        // Window starts at 0 and nothing has scaled yet, so the origin pixel is active.
        comp_vec("mix_z2",        2'd2, 8'd3, 3'b111, 1'b1, 8'd7);
        check("mix_valid", display_valid, 1);
        comp_vec("mix_z3",        2'd3, 8'd3, 3'b111, 1'b1, 8'd3);
        comp_vec("mix_z1",        2'd1, 8'd3, 3'b111, 1'b1, 8'd7);
        comp_vec("mix_z0",        2'd0, 8'd3, 3'b111, 1'b1, 8'd7);
        comp_vec("mix_spr_off",   2'd3, 8'd3, 3'b111, 1'b0, 8'd7);
        comp_vec("mix_col0",      2'd3, 8'd0, 3'b111, 1'b1, 8'd7);
        comp_vec("mix_no_layers", 2'd1, 8'd3, 3'b000, 1'b1, 8'd3);
        comp_vec("mix_l1_off",    2'd0, 8'd0, 3'b101, 1'b1, 8'd5);
        comp_vec("mix_z2_l0",     2'd2, 8'd3, 3'b001, 1'b1, 8'd3);
        comp_vec("mix_z2_under",  2'd2, 8'd3, 3'b110, 1'b1, 8'd7);
        layer_key = '0;
        comp_vec("mix_key_off",   2'd3, 8'd3, 3'b111, 1'b1, 8'd9);
        comp_vec("mix_blank",     2'd0, 8'd0, 3'b000, 1'b1, 8'd0);
        layer_key = {8'd9, 8'd0, 8'd0};

        // Two-clock latency from counter state to display output.
        active_hstart = 10'd2;
        do_line(irq);
        check("lat_border_valid", display_valid, 0);
        check("lat_border_data", display_data, 8'hEE);
        do_pixel();
        do_pixel();
        check("lat_t0", display_valid, 0);
        tick(1);
        check("lat_t1", display_valid, 0);
        tick(1);
        check("lat_t2", display_valid, 1);
        active_hstart = '0;

        do_line(irq);
        for (int k = 1; k <= 8; k++) begin
            do_pixel();
            check("rdidx_x1", lb_if.lb_rdidx, k);
        end
        frac_x_incr = 8'd64;
        do_line(irq);
        for (int k = 1; k <= 8; k++) begin
            do_pixel();
            check("rdidx_x05", lb_if.lb_rdidx, k / 2);
        end
        frac_x_incr = 8'd255;
        do_line(irq);
        for (int k = 1; k <= 330; k++) begin
            do_pixel();
            if (k == 321) check("rdidx_pre_sat", lb_if.lb_rdidx, 639);
            if (k == 322) check("rdidx_sat", lb_if.lb_rdidx, 640);
            if (k == 330) check("rdidx_hold", lb_if.lb_rdidx, 640);
        end

        do_line(irq);
        for (int k = 1; k <= 640; k++) begin
            do_pixel();
            if (k >= 638) check("erase", lb_if.sprite_lb_erase_start, k == 639);
        end

        // Interlaced: odd field starts at line 1 and steps by 2.
        interlaced = 1'b1;  irqline = 9'd6;  frac_x_incr = 8'd128;
        do_frame();
        check("il_scan_start", scanline, 1);
        check("il_field", current_field, 1);
        for (int k = 0; k < 4; k++) begin
            do_line(irq);
            check("il_irq", irq, k == 3);
        end
        check("il_scan_step", scanline, 9);
        for (int k = 0; k < 4; k++) do_pixel();
        check("il_rdidx", lb_if.lb_rdidx, 2);

        interlaced = 1'b0;  irqline = 9'd5;
        do_frame();
        for (int k = 0; k < 7; k++) begin
            do_line(irq);
            check("ni_irq", irq, k == 5);
        end

        active_vstart = 9'd10;
        do_frame();
        for (int k = 1; k <= 12; k++) begin
            do_line(irq);
            if (k == 9)  check("vs_render_pre", lb_if.line_render_start, 0);
            if (k == 10) check("vs_render", lb_if.line_render_start, 1);
            if (k == 10) check("vs_idx0", lb_if.line_idx, 0);
            if (k == 11) check("vs_idx1", lb_if.line_idx, 1);
            if (k == 12) check("vs_idx2", lb_if.line_idx, 2);
        end

        frac_y_incr = 8'd255;
        do_frame();
        for (int k = 1; k <= 252; k++) begin
            do_line(irq);
            if (k == 11)  check("ysat_idx1", lb_if.line_idx, 1);
            if (k == 12)  check("ysat_idx3", lb_if.line_idx, 3);
            if (k == 12)  check("ysat_valid", display_valid, 1);
            if (k == 250) check("ysat_idx478", lb_if.line_idx, 478);
            if (k == 251) check("ysat_idx480", lb_if.line_idx, 480);
            if (k == 251) check("ysat_render_last", lb_if.line_render_start, 1);
            if (k == 252) check("ysat_hold", lb_if.line_idx, 480);
            if (k == 252) check("ysat_render_stop", lb_if.line_render_start, 0);
        end
        tick(2);
        check("ysat_border_valid", display_valid, 0);
        check("ysat_border_data", display_data, 8'hEE);

        // Interlaced with field/vstart parity mismatch preloads one increment.
        interlaced = 1'b1;  frac_y_incr = 8'd128;
        do_frame();
        for (int k = 1; k <= 6; k++) begin
            do_line(irq);
            if (k == 4) check("il_vs_pre", lb_if.line_render_start, 0);
            if (k == 5) check("il_vs_render", lb_if.line_render_start, 1);
            if (k == 5) check("il_vs_idx1", lb_if.line_idx, 1);
            if (k == 6) check("il_vs_idx3", lb_if.line_idx, 3);
        end

        // Reset in the middle of an active line.
        interlaced = 1'b0;  active_vstart = '0;
        do_frame();
        do_line(irq);
        for (int k = 0; k < 3; k++) do_pixel();
        tick(2);
        check("pre_rst_valid", display_valid, 1);
        check("pre_rst_rdidx", lb_if.lb_rdidx, 3);
        rst = 1'b1;
        tick(1);
        check("mid_rst_data",  display_data, 0);
        check("mid_rst_valid", display_valid, 0);
        check("mid_rst_rdidx", lb_if.lb_rdidx, 0);
        check("mid_rst_field", current_field, 0);
        check("mid_rst_scan",  scanline, 0);
        rst = 1'b0;
        tick(1);
        active_vstart = 9'd10;
        do_frame();
        check("rerun_field", current_field, 1);
        for (int k = 1; k <= 11; k++) begin
            do_line(irq);
            if (k == 9)  check("rerun_render_pre", lb_if.line_render_start, 0);
            if (k == 10) check("rerun_idx0", lb_if.line_idx, 0);
            if (k == 10) check("rerun_render", lb_if.line_render_start, 1);
            if (k == 11) check("rerun_idx1", lb_if.line_idx, 1);
        end
        check("rerun_scan", scanline, 11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
